// File: rtl/display_scan_mux_if.sv
// rtl/display_scan_mux_if.sv - display data, digit mask and scan output bundle
interface display_scan_mux_if #(
  parameter int DIGITS = 4,
  parameter int DATA_W = 4,
  parameter int SEL_W  = $clog2(DIGITS)
);
  logic [DIGITS*DATA_W-1:0] DIGIT_DATA;
  logic                     LOAD;
  logic [DIGITS-1:0]        DIGIT_EN;
  logic [DATA_W-1:0]        OUTPUT;
  logic [DIGITS-1:0]        ANODE;
  logic [SEL_W-1:0]         SEL;
  logic                     FRAME;

  modport master (
    output DIGIT_DATA, LOAD, DIGIT_EN,
    input  OUTPUT, ANODE, SEL, FRAME
  );

  modport slave (
    input  DIGIT_DATA, LOAD, DIGIT_EN,
    output OUTPUT, ANODE, SEL, FRAME
  );
endinterface

// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - time-multiplexed digit scanner with blanking and double-buffered data
module display_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16,
  parameter int SEL_W    = $clog2(DIGITS)
) (
  input logic               CLK,
  input logic               RESET_N,
  display_scan_mux_if.slave bus
);
  localparam int                CNT_W     = $clog2(PRESCALE);
  localparam int                BUF_W     = DIGITS * DATA_W;
  localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK);
  localparam logic [SEL_W-1:0]  IDX_LAST  = SEL_W'(DIGITS - 1);

  logic [CNT_W-1:0]  r_slot_cnt;
  logic [SEL_W-1:0]  r_idx;
  logic [BUF_W-1:0]  r_stage;
  logic [BUF_W-1:0]  r_disp;
  logic              r_pending;
  logic [DATA_W-1:0] r_output;
  logic [DIGITS-1:0] r_anode;
  logic              r_frame;

  logic              w_slot_wrap;
  logic              w_frame_end;
  logic [CNT_W-1:0]  w_slot_nxt;
  logic [SEL_W-1:0]  w_idx_nxt;
  logic [BUF_W-1:0]  w_disp_nxt;
  logic              w_drive_nxt;
  logic [DIGITS-1:0] w_anode_nxt;
  logic [DATA_W-1:0] w_out_nxt;
  logic              w_frame_nxt;

  // Outputs are computed from the next counter state so they land on the
  // same edge that moves the counters, keeping every output registered.
  always_comb begin
    w_slot_wrap = (r_slot_cnt == SLOT_LAST);
    w_frame_end = w_slot_wrap && (r_idx == IDX_LAST);
    w_slot_nxt  = w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    if (w_slot_wrap) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end

    w_disp_nxt = r_disp;
    if (w_frame_end) begin
      if (bus.LOAD) begin
        w_disp_nxt = bus.DIGIT_DATA;
      end else if (r_pending) begin
        w_disp_nxt = r_stage;
      end
    end

    w_drive_nxt = (w_slot_nxt >= BLANK_END);
    w_anode_nxt = '1;
    w_out_nxt   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_idx_nxt == SEL_W'(i)) begin
        w_out_nxt      = w_disp_nxt[i*DATA_W +: DATA_W];
        w_anode_nxt[i] = ~(w_drive_nxt & bus.DIGIT_EN[i]);
      end
    end

    w_frame_nxt = (w_idx_nxt == IDX_LAST) && (w_slot_nxt == SLOT_LAST);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_slot_cnt <= '0;
      r_idx      <= '0;
      r_stage    <= '0;
      r_disp     <= '0;
      r_pending  <= 1'b0;
      r_output   <= '0;
      r_anode    <= '1;
      r_frame    <= 1'b0;
    end else begin
      r_slot_cnt <= w_slot_nxt;
      r_idx      <= w_idx_nxt;
      r_disp     <= w_disp_nxt;
      r_output   <= w_out_nxt;
      r_anode    <= w_anode_nxt;
      r_frame    <= w_frame_nxt;
      if (bus.LOAD) begin
        r_stage <= bus.DIGIT_DATA;
      end
      // A frame-end edge always consumes the stage; a load there bypasses it.
      if (w_frame_end) begin
        r_pending <= 1'b0;
      end else if (bus.LOAD) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign bus.OUTPUT = r_output;
  assign bus.ANODE  = r_anode;
  assign bus.SEL    = r_idx;
  assign bus.FRAME  = r_frame;
endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - directed-vector bench for display_scan_mux
module tb_display_scan_mux;
  localparam int DIGITS   = 4;
  localparam int DATA_W   = 4;
  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  int         vectors = 0;
  int         errors = 0;
  int         pos = 0;
  logic [2:0] m_slot = 3'd0;
  logic [3:0] prev_out = 4'd0;

  display_scan_mux_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus ();

  display_scan_mux #(
    .DIGITS(DIGITS), .DATA_W(DATA_W), .PRESCALE(PRESCALE), .BLANK(BLANK)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] exp_anode(int p, logic [3:0] en);
    logic [3:0] r;
    int slot, idx;
    slot = p % 8;
    idx  = (p / 8) % 4;
    r = 4'hF;
    if (slot >= 2 && en[idx]) r[idx] = 1'b0;
    return r;
  endfunction

  task automatic step();
    @(negedge CLK);
    pos++;
  endtask

  task automatic goto(int target);
    while (pos % 32 != target) step();
  endtask

  // Free-running slot reference for the every-cycle ghosting guard.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) m_slot <= 3'd0;
    else          m_slot <= m_slot + 3'd1;
  end

  always @(negedge CLK) begin
    if (RESET_N) begin
      vectors++;
      if (m_slot < 3'd2 && bus.ANODE !== 4'hF) begin
        errors++;
        $display("FAIL ghost_blank slot=%0d anode got %b want 1111", m_slot, bus.ANODE);
      end
      vectors++;
      if ($countones(~bus.ANODE) > 1) begin
        errors++;
        $display("FAIL ghost_onehot anode got %b want at most one low", bus.ANODE);
      end
      if (bus.OUTPUT !== prev_out) begin
        vectors++;
        if (bus.ANODE !== 4'hF) begin
          errors++;
          $display("FAIL ghost_change output %h->%h with anode got %b want 1111", prev_out, bus.OUTPUT, bus.ANODE);
        end
      end
    end
    prev_out = bus.OUTPUT;
  end

  task automatic test_reset();
    RESET_N = 1'b0;
    bus.LOAD = 1'b0;
    bus.DIGIT_DATA = 16'h0;
    bus.DIGIT_EN = 4'b1111;
    repeat (3) @(negedge CLK);
    vectors += 4;
    if (bus.ANODE !== 4'hF) begin errors++; $display("FAIL rst_anode got %b want 1111", bus.ANODE); end
    if (bus.OUTPUT !== 4'h0) begin errors++; $display("FAIL rst_output got %h want 0", bus.OUTPUT); end
    if (bus.SEL !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d want 0", bus.SEL); end
    if (bus.FRAME !== 1'b0) begin errors++; $display("FAIL rst_frame got %b want 0", bus.FRAME); end
    RESET_N = 1'b1;
    pos = 0;
    vectors++;
    if (bus.ANODE !== 4'hF) begin errors++; $display("FAIL rel_anode got %b want 1111", bus.ANODE); end
    for (int k = 0; k < 32; k++) begin
      step();
      vectors += 3;
      if (bus.ANODE !== exp_anode(pos, 4'hF)) begin
        errors++; $display("FAIL scan_anode pos=%0d got %b want %b", pos, bus.ANODE, exp_anode(pos, 4'hF));
      end
      if (bus.SEL !== 2'((pos / 8) % 4)) begin
        errors++; $display("FAIL scan_sel pos=%0d got %0d want %0d", pos, bus.SEL, (pos / 8) % 4);
      end
      if (bus.FRAME !== ((pos % 32) == 31)) begin
        errors++; $display("FAIL scan_frame pos=%0d got %b want %b", pos, bus.FRAME, (pos % 32) == 31);
      end
    end
  endtask

  task automatic test_load();
    goto(5);
    bus.DIGIT_DATA = 16'h4321;
    bus.LOAD = 1'b1;
    step();
    bus.LOAD = 1'b0;
    while (pos % 32 != 0) begin
      vectors++;
      if (bus.OUTPUT !== 4'h0) begin errors++; $display("FAIL load_hold pos=%0d got %h want 0", pos, bus.OUTPUT); end
      step();
    end
    for (int i = 0; i < 32; i++) begin
      vectors += 2;
      if (bus.OUTPUT !== 4'((pos / 8) % 4 + 1)) begin
        errors++; $display("FAIL load_show pos=%0d got %h want %h", pos, bus.OUTPUT, (pos / 8) % 4 + 1);
      end
      if (bus.SEL !== 2'((pos / 8) % 4)) begin
        errors++; $display("FAIL load_sel pos=%0d got %0d want %0d", pos, bus.SEL, (pos / 8) % 4);
      end
      step();
    end
  endtask

  task automatic test_mask();
    goto(31);
    bus.DIGIT_EN = 4'b1011;
    step();
    for (int i = 0; i < 32; i++) begin
      vectors += 2;
      if (bus.ANODE !== exp_anode(pos, 4'b1011)) begin
        errors++; $display("FAIL mask_anode pos=%0d got %b want %b", pos, bus.ANODE, exp_anode(pos, 4'b1011));
      end
      if (bus.SEL !== 2'((pos / 8) % 4)) begin
        errors++; $display("FAIL mask_sel pos=%0d got %0d want %0d", pos, bus.SEL, (pos / 8) % 4);
      end
      if (i == 31) bus.DIGIT_EN = 4'b1111;
      step();
    end
  endtask

  task automatic test_bypass_last_wins();
    goto(3);
    bus.DIGIT_DATA = 16'hAAAA;
    bus.LOAD = 1'b1;
    step();
    bus.LOAD = 1'b0;
    goto(10);
    bus.DIGIT_DATA = 16'h5555;
    bus.LOAD = 1'b1;
    step();
    bus.LOAD = 1'b0;
    while (pos % 32 != 31) begin
      vectors++;
      if (bus.OUTPUT !== 4'((pos / 8) % 4 + 1)) begin
        errors++; $display("FAIL lw_hold pos=%0d got %h want %h", pos, bus.OUTPUT, (pos / 8) % 4 + 1);
      end
      step();
    end
    vectors += 2;
    if (bus.FRAME !== 1'b1) begin errors++; $display("FAIL lw_frame got %b want 1", bus.FRAME); end
    if (bus.OUTPUT !== 4'h4) begin errors++; $display("FAIL lw_last got %h want 4", bus.OUTPUT); end
    step();
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (bus.OUTPUT !== 4'h5) begin errors++; $display("FAIL lw_show pos=%0d got %h want 5", pos, bus.OUTPUT); end
      if (i == 31) begin
        vectors++;
        if (bus.FRAME !== 1'b1) begin errors++; $display("FAIL byp_frame got %b want 1", bus.FRAME); end
        bus.DIGIT_DATA = 16'h9999;
        bus.LOAD = 1'b1;
      end
      step();
    end
    bus.LOAD = 1'b0;
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (bus.OUTPUT !== 4'h9) begin errors++; $display("FAIL byp_show pos=%0d got %h want 9", pos, bus.OUTPUT); end
      step();
    end
  endtask

  task automatic test_async_reset();
    goto(3);
    bus.DIGIT_DATA = 16'h7777;
    bus.LOAD = 1'b1;
    step();
    bus.LOAD = 1'b0;
    goto(20);
    vectors += 3;
    if (bus.ANODE !== 4'b1011) begin errors++; $display("FAIL ar_pre_anode got %b want 1011", bus.ANODE); end
    if (bus.OUTPUT !== 4'h9) begin errors++; $display("FAIL ar_pre_output got %h want 9", bus.OUTPUT); end
    if (bus.SEL !== 2'd2) begin errors++; $display("FAIL ar_pre_sel got %0d want 2", bus.SEL); end
    #2;
    RESET_N = 1'b0;
    #1;
    vectors += 4;
    if (bus.ANODE !== 4'hF) begin errors++; $display("FAIL ar_anode got %b want 1111", bus.ANODE); end
    if (bus.OUTPUT !== 4'h0) begin errors++; $display("FAIL ar_output got %h want 0", bus.OUTPUT); end
    if (bus.SEL !== 2'd0) begin errors++; $display("FAIL ar_sel got %0d want 0", bus.SEL); end
    if (bus.FRAME !== 1'b0) begin errors++; $display("FAIL ar_frame got %b want 0", bus.FRAME); end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    pos = 0;
    for (int i = 0; i < 64; i++) begin
      vectors += 3;
      if (bus.OUTPUT !== 4'h0) begin errors++; $display("FAIL ar_lost pos=%0d got %h want 0", pos, bus.OUTPUT); end
      if (bus.ANODE !== exp_anode(pos, 4'hF)) begin
        errors++; $display("FAIL ar_anode_scan pos=%0d got %b want %b", pos, bus.ANODE, exp_anode(pos, 4'hF));
      end
      if (bus.SEL !== 2'((pos / 8) % 4)) begin
        errors++; $display("FAIL ar_sel_scan pos=%0d got %0d want %0d", pos, bus.SEL, (pos / 8) % 4);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_mask();
    test_bypass_last_wins();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Parametrised time-multiplexed display scanner for the multiplexed-display path. It selects one of `DIGITS` digit codes at a time and drives the matching active-low digit enable, stepping through all digits at a programmable slot rate. A blanking interval at the start of each slot suppresses ghosting. New display data is double-buffered so a whole frame always shows one consistent value. Sits between the value-formatting logic and the segment decoder / digit-enable pins.

## Interface

**Parameters**
- `DIGITS`, default 4: number of digits scanned; must be at least 2.
- `DATA_W`, default 4: width of one digit code.
- `PRESCALE`, default 50000: clock cycles per digit slot; must be at least 2.
- `BLANK`, default 16: blank cycles at the start of each slot; must satisfy 0 <= `BLANK` < `PRESCALE`.
- `SEL_W`, default `$clog2(DIGITS)`: width of the digit index.

**Ports**
- `CLK` input, 1: single clock; all logic is on its rising edge.
- `RESET_N` input, 1: reset, asynchronous and active-low.
- `DIGIT_DATA` input, `DIGITS*DATA_W`: digit codes; digit *i* is bits `[i*DATA_W +: DATA_W]`.
- `LOAD` input, 1: one-cycle strobe that captures `DIGIT_DATA`.
- `DIGIT_EN` input, `DIGITS`: per-digit mask (1 = digit may light); sampled live.
- `OUTPUT` output, `DATA_W`: code of the digit currently selected.
- `ANODE` output, `DIGITS`: active-low digit enables, one-hot-low or all ones.
- `SEL` output, `SEL_W`: current digit index.
- `FRAME` output, 1: one-cycle pulse on the last cycle of each frame.

## Operation

**State**
- `slot_cnt`: counts 0..`PRESCALE-1`.
- `idx`: counts 0..`DIGITS-1`.
- `stage_reg` and `disp_reg`, each `DIGITS*DATA_W`.
- `pending`: 1 bit.

**Slot phases (per slot)**
- BLANK phase, `slot_cnt` < `BLANK`: `ANODE` is all ones.
- DRIVE phase, otherwise: `ANODE[idx]` = ~`DIGIT_EN[idx]`; all other bits are 1.

**Counters**
- `slot_cnt` increments every cycle and wraps `PRESCALE-1` -> 0.
- On that wrap, `idx` increments and wraps `DIGITS-1` -> 0.

**Outputs**
- `OUTPUT` = `disp_reg` digit `idx` at all times, so it changes at slot start, inside BLANK.
- `SEL` = `idx`.
- Frame end is the cycle where `idx == DIGITS-1` and `slot_cnt == PRESCALE-1`. `FRAME` = 1 on exactly that cycle.

**Load handling**
- `LOAD` on a non-frame-end cycle: `stage_reg` <= `DIGIT_DATA`, `pending` <= 1. A later `LOAD` overwrites the staged value (last wins).
- Frame-end edge with `pending` = 1: `disp_reg` <= `stage_reg`, `pending` <= 0.
- `LOAD` on the frame-end cycle: `disp_reg` <= `DIGIT_DATA` directly (bypass). `stage_reg` is also updated and `pending` <= 0.
- `disp_reg` changes only at frame-end edges. There is no tearing within a frame.

**Masking**
- A masked digit (`DIGIT_EN[i]` = 0) still occupies its slot with `ANODE` all ones. Scan timing is unchanged.

**Reset**
- `RESET_N` low immediately forces, without a clock edge:
  - `slot_cnt` = 0, `idx` = 0, `pending` = 0
  - `stage_reg` = 0, `disp_reg` = 0
  - `ANODE` = all ones, `OUTPUT` = 0, `SEL` = 0, `FRAME` = 0
- Reset mid-slot or mid-frame abandons the scan and any pending load.

## Timing

- All outputs are registered, with no combinational path from input to output. Each output updates on the same edge that moves the counters to the state it reflects.
- Cycle 0 is the first rising edge after `RESET_N` rises. Counters reach `slot_cnt` = 1 on that edge.
- A digit is lit for `PRESCALE-BLANK` cycles per slot.
- A frame lasts `DIGITS*PRESCALE` cycles.
- Refresh rate per digit is f_CLK / (`DIGITS*PRESCALE`).
- `DIGIT_EN` change: reflected in `ANODE` one edge later.
- `LOAD` latency to display: at most one frame plus one cycle, and exactly 1 cycle in the bypass case.
- `FRAME` never asserts for two consecutive cycles.

## Test plan

All scenarios use `DIGITS`=4, `DATA_W`=4, `PRESCALE`=8, `BLANK`=2, giving a 32-cycle frame.

1. **Reset and first slot.** Hold `RESET_N` low, then release with `DIGIT_EN`=4'b1111 -> during reset, `ANODE`=4'b1111, `OUTPUT`=0, `SEL`=0, `FRAME`=0. After release, slot 0 shows `ANODE`=4'b1111 for 2 cycles, then 4'b1110 for 6 cycles. `SEL` steps 0,1,2,3 every 8 cycles. `FRAME` pulses once per 32 cycles.
2. **Double-buffered load.** Pulse `LOAD` with `DIGIT_DATA`=16'h4321 mid-frame -> `OUTPUT` stays 0 until the frame-end edge. The next frame shows `OUTPUT` 1,2,3,4 for `SEL` 0..3.
3. **Masking.** Set `DIGIT_EN`=4'b1011 -> `ANODE[2]` stays 1 for an entire frame. The other digits' DRIVE windows are unchanged. `SEL` still visits 2.
4. **Bypass and last-wins.** Pulse `LOAD` with 16'hAAAA, then `LOAD` with 16'h5555 in the same frame -> the next frame shows 5. Then pulse `LOAD` with 16'h9999 exactly on the `FRAME` cycle -> the next slot shows 9 and no stale value appears.
5. **Asynchronous reset.** Drop `RESET_N` during DRIVE of digit 2 with a load pending -> `ANODE` goes to 4'b1111 and `OUTPUT` to 0 before the next `CLK` edge. After release, the display shows 0 and the pending data is lost.
6. **Ghosting guard.** Check every cycle -> `ANODE` is never low during `slot_cnt` < 2. `OUTPUT` never changes while any `ANODE` bit is low. At most one `ANODE` bit is low at a time.
